neuron_gen: RTL

NEURON_GEN -- requirements
Module: neuron_gen

---
 rtl/neuron_gen_pkg.sv | 24 ++
 rtl/neuron_gen_act.sv | 63 ++++++
 rtl/neuron_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/neuron_gen_pkg.sv
// Shared types for the neuron_gen block: activation codes, FSM states,
// and the accumulator sizing helper.
package neuron_gen_pkg;

  typedef enum logic [1:0] {
    ACT_ID   = 2'd0,
    ACT_RELU = 2'd1,
    ACT_HSIG = 2'd2,
    ACT_RSV  = 2'd3
  } act_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_ACT,
    S_OUT
  } state_e;

  function automatic int acc_width(input int dw, input int nw);
    return 2 * dw + $clog2(nw);
  endfunction

endpackage

// File: rtl/neuron_gen_act.sv
// Output stage: rescale the accumulator, clip it to the data range,
// and apply the selected activation. Registered, one cycle.
module neuron_act
  import neuron_gen_pkg::*;
#(
  parameter int ACC_W      = 35,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] acc,
  input  act_e                    act,
  output logic [DATA_WIDTH-1:0]   data,
  output logic                    sat
);

  localparam int DW = DATA_WIDTH;
  localparam logic signed [DW:0] HALF =
    (DW+1)'(1) <<< (FRAC_WIDTH - 1);
  localparam logic signed [DW:0] ONE =
    (DW+1)'(1) <<< FRAC_WIDTH;

  logic signed [ACC_W-1:0] sh;
  logic signed [DW-1:0]    x;
  logic signed [DW:0]      hs;
  logic                    clip;
  logic [DW-1:0]           y;

  always_comb begin
    sh   = acc >>> FRAC_WIDTH;
    clip = sh[ACC_W-1:DW-1] !=
           {(ACC_W-DW+1){sh[ACC_W-1]}};
    x    = sh[DW-1:0];
    if (clip)
      x = sh[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}}
                      : {1'b0, {(DW-1){1'b1}}};
    // x/4 + 0.5, one extra bit so the offset never wraps
    hs = ($signed({x[DW-1], x}) >>> 2) + HALF;
    if (hs < 0)
      hs = '0;
    else if (hs > ONE)
      hs = ONE;
    y = x;
    unique case (1'b1)
      (act == ACT_RELU): y = x[DW-1] ? '0 : x;
      (act == ACT_HSIG): y = hs[DW-1:0];
      (act == ACT_ID || act == ACT_RSV): y = x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      sat  <= 1'b0;
    end else if (en) begin
      data <= y;
      sat  <= clip;
    end
  end

endmodule

// File: rtl/neuron_gen.sv
// One neuron: weight/bias store, LANES-wide MAC pipeline and
// activated result behind a valid/ready handshake.
module neuron_gen
  import neuron_gen_pkg::*;
#(
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 128,
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int CFG_WIDTH  = 33
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CFG_WIDTH-1:0]        cfg_layer_num,
  input  logic [CFG_WIDTH-1:0]        cfg_neuron_num,
  input  logic                        weight_valid,
  input  logic [DATA_WIDTH-1:0]       weight_value,
  input  logic                        bias_valid,
  input  logic [DATA_WIDTH-1:0]       bias_value,
  input  logic [1:0]                  act_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_sat,
  output logic                        busy
);

  localparam int DW    = DATA_WIDTH;
  localparam int ACC_W = acc_width(DATA_WIDTH, NUM_WEIGHT);
  localparam int WORDS = NUM_WEIGHT / LANES;
  localparam int WW    = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;

  state_e state, state_n;
  act_e   act_q;
  logic   drain_q;
  logic [WW-1:0] beat_cnt, wr_word;
  logic [LW-1:0] wr_lane;
  logic [DW-1:0] wmem [WORDS][LANES];
  logic [DW-1:0] w_q [LANES];
  logic [LANES*DW-1:0] x_q;
  logic signed [2*DW-1:0] p_q [LANES];
  logic signed [ACC_W-1:0] bias_q, acc_q, tree;
  logic v0, v1, f0, f1;
  logic cfg_hit, w_ld, b_ld, beat, last;

  assign cfg_hit = state == S_IDLE &&
    cfg_layer_num == CFG_WIDTH'(LAYER_NO) &&
    cfg_neuron_num == CFG_WIDTH'(NEURON_NO);
  assign w_ld      = weight_valid && cfg_hit;
  assign b_ld      = bias_valid && cfg_hit;
  assign in_ready  = state == S_IDLE || state == S_ACCUM;
  assign beat      = in_valid && in_ready;
  assign last      = beat_cnt == WW'(WORDS - 1);
  assign busy      = state != S_IDLE;
  assign out_valid = state == S_OUT;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (beat) state_n = last ? S_DRAIN : S_ACCUM;
      S_ACCUM: if (beat && last) state_n = S_DRAIN;
      S_DRAIN: if (drain_q) state_n = S_ACT;
      S_ACT:   state_n = S_OUT;
      S_OUT:   if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Weight memory survives reset on purpose
  always_ff @(posedge clk) begin
    if (w_ld && !rst)
      wmem[wr_word][wr_lane] <= weight_value;
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      x_q <= in_data;
      for (int l = 0; l < LANES; l++)
        w_q[l] <= wmem[beat_cnt][l];
    end
    for (int l = 0; l < LANES; l++)
      p_q[l] <= $signed(x_q[l*DW +: DW]) * $signed(w_q[l]);
  end

  always_comb begin
    tree = '0;
    for (int l = 0; l < LANES; l++)
      tree = tree + ACC_W'(p_q[l]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      drain_q  <= 1'b0;
      beat_cnt <= '0;
      wr_word  <= '0;
      wr_lane  <= '0;
      bias_q   <= '0;
      acc_q    <= '0;
      act_q    <= ACT_ID;
      v0       <= 1'b0;
      f0       <= 1'b0;
      v1       <= 1'b0;
      f1       <= 1'b0;
    end else begin
      state   <= state_n;
      drain_q <= state == S_DRAIN && !drain_q;
      if (w_ld) begin
        if (wr_lane == LW'(LANES - 1)) begin
          wr_lane <= '0;
          wr_word <= wr_word == WW'(WORDS - 1) ? '0
                                               : wr_word + 1'b1;
        end else begin
          wr_lane <= wr_lane + 1'b1;
        end
      end
      if (b_ld)
        bias_q <= {{(ACC_W-DW){bias_value[DW-1]}}, bias_value}
                  << FRAC_WIDTH;
      if (beat) begin
        beat_cnt <= last ? '0 : beat_cnt + 1'b1;
        if (state == S_IDLE)
          act_q <= act_e'(act_sel);
      end
      v0 <= beat;
      f0 <= beat && state == S_IDLE;
      v1 <= v0;
      f1 <= f0;
      if (v1)
        acc_q <= (f1 ? bias_q : acc_q) + tree;
    end
  end

  neuron_act #(
    .ACC_W      (ACC_W),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_act (
    .clk  (clk),
    .rst  (rst),
    .en   (state == S_ACT),
    .acc  (acc_q),
    .act  (act_q),
    .data (out_data),
    .sat  (out_sat)
  );

endmodule
